// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with hold timeout
// Issues a registered one-hot grant, held until done, request drop or timeout.
module rr_arbiter8 #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] gnt_q, gnt_d;
   logic       gnt_valid_q, gnt_valid_d;
   logic       timeout_q, timeout_d;

   logic [2:0] idx;
   logic [2:0] pick;
   logic       found;
   logic       owner_req;
   logic       at_limit;

   // wrap-around search starting at ptr_q
   always_comb begin
      idx   = 3'd0;
      pick  = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr_q + 3'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign owner_req = |(req & gnt_q);
   assign at_limit  = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d       = 8'h00;
            gnt_valid_d = 1'b0;
            if (found) begin
               gnt_d       = 8'h01 << pick;
               gnt_valid_d = 1'b1;
               ptr_d       = pick + 3'd1;
               cnt_d       = 8'd0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            cnt_d = cnt_q + 8'd1;
            if (done || !owner_req || at_limit) begin
               gnt_d       = 8'h00;
               gnt_valid_d = 1'b0;
               state_d     = IDLE;
               // only a pure expiry counts as a forced revoke
               timeout_d   = at_limit && !done && owner_req;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 3'd0;
         cnt_q       <= 8'd0;
         gnt_q       <= 8'h00;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule
